// File: rtl/csr_bank.sv
// Control/status register bank: registered 1-cycle reads, W1C events with masked irq, write pulses, double-buffered config.
// Always accepts re/we (no backpressure); rdata/rvalid, pulse_o and irq_o are registered one edge after sampling.
module csr_bank #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter int          AWIDTH    = $clog2(DEPTH),
  parameter int          NUM_EVT   = 16,
  parameter int          NUM_PULSE = 8,
  parameter int          NUM_RO    = 4,
  parameter int          NUM_CFG   = 16,
  parameter logic [7:0]  CHIP_ID   = 8'h00,
  parameter logic [7:0]  VERSION   = 8'h02
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AWIDTH-1:0]                addr,
  input  logic                             we,
  input  logic                             re,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [DATA_W/8-1:0]              wmask,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rvalid,
  input  logic [NUM_EVT-1:0]               evt_i,
  input  logic [NUM_RO-1:0][DATA_W-1:0]    ro_i,
  input  logic                             commit_i,
  output logic [NUM_CFG-1:0][DATA_W-1:0]   cfg_o,
  output logic [NUM_PULSE-1:0]             pulse_o,
  output logic                             irq_o
);

  localparam int NB     = DATA_W / 8;
  localparam int A_ID   = 0;
  localparam int A_CTRL = 1;
  localparam int A_STAT = 2;
  localparam int A_EN   = 3;
  localparam int A_RO   = 4;
  localparam int A_CFG  = 8;

  logic [DATA_W-1:0]              bmask;
  logic [DATA_W-1:0]              wdat_m;
  logic [NUM_EVT-1:0]             stat_q;
  logic [NUM_EVT-1:0]             en_q;
  logic [NUM_EVT-1:0]             stat_clr;
  logic [NUM_CFG-1:0][DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0]              rd_mux;
  logic                           wr_ctrl;
  logic                           wr_stat;
  logic                           wr_en;
  logic                           commit;

  for (genvar b = 0; b < NB; b++) begin : g_bmask
    assign bmask[b*8 +: 8] = {8{wmask[b]}};
  end

  // Every write effect (W1C, pulse, commit, RW) only sees enabled bytes.
  assign wdat_m   = wdata & bmask;
  assign wr_ctrl  = we && (addr == AWIDTH'(A_CTRL));
  assign wr_stat  = we && (addr == AWIDTH'(A_STAT));
  assign wr_en    = we && (addr == AWIDTH'(A_EN));
  assign stat_clr = wr_stat ? wdat_m[NUM_EVT-1:0] : '0;
  assign commit   = commit_i || (wr_ctrl && wdat_m[DATA_W-1]);

  always_comb begin
    rd_mux = '0;
    if (addr == AWIDTH'(A_ID)) begin
      rd_mux[15:0] = {VERSION, CHIP_ID};
    end else if (addr == AWIDTH'(A_STAT)) begin
      rd_mux[NUM_EVT-1:0] = stat_q;
    end else if (addr == AWIDTH'(A_EN)) begin
      rd_mux[NUM_EVT-1:0] = en_q;
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (addr == AWIDTH'(A_RO + i)) rd_mux = ro_i[i];
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      if (addr == AWIDTH'(A_CFG + i)) rd_mux = shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= '0;
      en_q    <= '0;
      irq_o   <= 1'b0;
      pulse_o <= '0;
      cfg_o   <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      // A new event outranks a same-cycle clear.
      stat_q  <= evt_i | (stat_q & ~stat_clr);
      if (wr_en) en_q <= (en_q & ~bmask[NUM_EVT-1:0]) | wdat_m[NUM_EVT-1:0];
      irq_o   <= |(stat_q & en_q);
      pulse_o <= wr_ctrl ? wdat_m[NUM_PULSE-1:0] : '0;
      if (commit) cfg_o <= shadow_q;
      rvalid  <= re;
      if (re) rdata <= rd_mux;
    end
  end

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q[i] <= '0;
      end else if (we && (addr == AWIDTH'(A_CFG + i))) begin
        shadow_q[i] <= (shadow_q[i] & ~bmask) | wdat_m;
      end
    end
  end

endmodule

// File: doc/csr_bank.md
# csr_bank

Parametrised control/status register bank for the DVS digital core, the successor to the fixed-map register file. It sits between the SPI memory interface and the datapath. It adds registered reads, sticky write-one-to-clear event status with a masked interrupt, and multi-bit pulse-on-write strobes. Configuration words are double-buffered: software writes shadow copies, and they reach the datapath atomically on a commit.

## Interface
Parameters:
- DATA_W, 32, word width; multiple of 8, 16..64
- DEPTH, 64, number of word addresses; power of 2
- AWIDTH, $clog2(DEPTH), address width
- NUM_EVT, 16, sticky event bits; 1..DATA_W
- NUM_PULSE, 8, pulse strobes; 1..DATA_W-1
- NUM_RO, 4, read-only hardware words; 1..4
- NUM_CFG, 16, shadowed config words; 8+NUM_CFG <= DEPTH
- CHIP_ID, 8'h00, hardwired ID byte
- VERSION, 8'h02, hardwired version byte

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  AWIDTH  word address
- we  in  1  write strobe
- re  in  1  read strobe
- wdata  in  DATA_W  write data
- wmask  in  DATA_W/8  byte write enables
- rdata  out  DATA_W  registered read data
- rvalid  out  1  one-cycle read-data-valid
- evt_i  in  NUM_EVT  level event inputs
- ro_i  in  NUM_RO x DATA_W  read-only hardware words
- commit_i  in  1  hardware commit strobe, e.g. frame boundary
- cfg_o  out  NUM_CFG x DATA_W  committed configuration
- pulse_o  out  NUM_PULSE  one-cycle strobes
- irq_o  out  1  registered interrupt

## Operation
Memory map (word addresses):
- **0 ID (RO):** [7:0] CHIP_ID, [15:8] VERSION, remaining bits 0.
- **1 CTRL (write-only):**
  - Writing 1 to bit k < NUM_PULSE raises pulse_o[k] for one cycle.
  - Writing 1 to bit DATA_W-1 is a software commit.
  - Reads return 0.
- **2 EVT_STATUS (W1C):**
  - Bit k sets on any cycle evt_i[k] is sampled high.
  - Writing 1 to bit k clears it.
  - If set and clear coincide in the same cycle, set wins.
- **3 EVT_ENABLE (RW):** bits above NUM_EVT-1 read 0.
- **4..4+NUM_RO-1 (RO):** ro_i words, sampled on the read edge.
- **8..8+NUM_CFG-1 CFG (RW shadow):**
  - Reads return the shadow value, not cfg_o.
- **All other addresses:** read 0; writes ignored.

Rules:
- wmask gates every byte-wise effect: W1C, pulse, commit bit, and shadow writes. A byte with its mask bit clear has no effect.
- **Commit** is triggered by commit_i or by a software commit. On commit, every cfg_o word loads from its shadow as the shadow stood before that edge.
  - A shadow write in the commit cycle lands in the shadow only and appears at the next commit.
- irq_o is registered: irq_o <= |(EVT_STATUS & EVT_ENABLE).
- All addresses are taken modulo DEPTH.

## Timing
- **Reset:** all registers, shadows, cfg_o, pulse_o, irq_o, rdata and rvalid are 0. Reset asserted mid-operation discards pending pulses and uncommitted shadows.
- **Write:** a write sampled at edge N is visible to a read sampled at edge N+1.
- **Pulse:** pulse_o[k] is high for exactly the cycle after edge N. Back-to-back writes give back-to-back pulses.
- **Read:** re sampled at edge N gives rdata and rvalid after edge N (1-cycle latency).
  - rvalid is a 1-cycle pulse; rdata holds until the next read.
  - re and we to the same address in the same cycle return the pre-write value.
- **Event/IRQ:** evt_i high at edge N sets the status bit after edge N; irq_o rises after edge N+1.
  - A W1C write at edge M drops irq_o after edge M+1, unless the event persists.
- **Commit:** cfg_o updates at the commit edge. Simultaneous commit_i and software commit produce a single commit.

## Test plan
- **Reset and ID:** reset, read addr 0 -> rdata=32'h0000_0200 (VERSION 8'h02, CHIP_ID 8'h00), rvalid high one cycle; all cfg_o = 0.
- **Shadow and commit:** write 32'hDEAD_BEEF to addr 8 -> cfg_o[0] stays 0 and a read of addr 8 returns DEAD_BEEF. Pulse commit_i -> cfg_o[0]=DEAD_BEEF. Then write 32'h1234_5678 to addr 8 with wmask=4'b0011 -> shadow=DEAD_5678.
- **Event and IRQ:** EVT_ENABLE=0x0004, pulse evt_i[2] one cycle -> status=0x0004, irq_o high two edges after the event. Write 0x0004 to addr 2 -> irq_o low. Hold evt_i[2] during the clear -> status stays 0x0004.
- **Pulse outputs:** write 0x0000_0081 to addr 1 -> pulse_o[0] and pulse_o[7] high for exactly one cycle, no commit. Write 0x8000_0000 -> cfg_o loads, no pulses.
- **Byte-masked clear:** status=0xFFFF, write 0xFFFF to addr 2 with wmask=4'b0001 -> status=0xFF00.
- **Reset mid-operation:** after shadow writes and a pending event, assert rst_n low -> all outputs 0 immediately. Unmapped addr 60 reads 0, and writes to it do not alter any register.
